mem_port_arbiter: RTL

- Shares one single-port instruction/data memory between the IF stage (instruction fetch) and the MEM stage (load/store) of the 5-stage MIPS pipeline.
- Grants one requester at a time and drives the memory port until the memory acknowledges.
- Returns read data and a one-cycle ready pulse, and raises per-stage stall signals so the hazard logic freezes IF or MEM while its access is pending.

---
 rtl/mem_port_arbiter.sv | 96 +++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between IF fetch and MEM load/store.
// Define ARB_TIMEOUT_EN to abort an ACCESS after TIMEOUT cycles without mem_ack.
module mem_port_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4,
   parameter int TIMEOUT    = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_ready,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_ready,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic              stall_if,
   output logic              stall_mem,
   output logic              err
);
   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
   state_t state, state_nx;
   logic own_d, lat_we, grant_d, abort;
   logic [ADDR_W-1:0] lat_addr;
   logic [DATA_W-1:0] lat_wdata, rd;
   logic [3:0] starve;
   // a fetch that has watched STARVE_MAX data grants in a row takes the port
   assign grant_d = d_req & ~(if_req & (starve == 4'(STARVE_MAX)));
`ifdef ARB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] tcnt;
   logic err_q;
   assign abort = ~mem_ack & (tcnt == TW'(TIMEOUT - 1));
   assign err = err_q;
   always_ff @(posedge clk)
      if (rst) begin
         tcnt  <= '0;
         err_q <= 1'b0;
      end else begin
         tcnt <= (state == ACCESS) ? tcnt + TW'(1) : '0;
         if (state == ACCESS && abort) err_q <= 1'b1;
      end
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT != 0);
   assign abort = 1'b0;
   assign err = 1'b0;
`endif
   assign rd = abort ? DATA_W'(32'hDEADBEEF) : mem_rdata;
   always_comb begin
      state_nx = (state == IDLE)   ? ((if_req | d_req) ? ACCESS : IDLE) :
                 (state == ACCESS) ? ((mem_ack | abort) ? DONE : ACCESS) : IDLE;
   end
   always_ff @(posedge clk)
      if (rst) begin
         state     <= IDLE;
         own_d     <= 1'b0;
         lat_we    <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         starve    <= '0;
         if_rdata  <= '0;
         d_rdata   <= '0;
      end else begin
         state <= state_nx;
         if (state == IDLE && (if_req | d_req)) begin
            own_d     <= grant_d;
            lat_we    <= grant_d & d_we;
            lat_addr  <= grant_d ? d_addr : if_addr;
            lat_wdata <= d_wdata;
         end
         starve <= ~if_req ? '0 : (state == IDLE) ? (grant_d ? starve + 4'd1 : '0) : starve;
         if (state == ACCESS && (mem_ack | abort) && !lat_we) begin
            if (own_d) d_rdata <= rd;
            else if_rdata <= rd;
         end
      end
   assign mem_en    = (state == ACCESS);
   assign mem_we    = mem_en & lat_we;
   assign mem_addr  = lat_addr;
   assign mem_wdata = lat_wdata;
   assign if_ready  = (state == DONE) & ~own_d;
   assign d_ready   = (state == DONE) & own_d;
   assign stall_if  = if_req & ~if_ready;
   assign stall_mem = d_req & ~d_ready;
endmodule
